// File: rtl/cla16_multiword_seq_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer:
// FSM state encoding, slice width and slice-counter sizing.
package cla16_multiword_seq_pkg;

    // Width of one arithmetic slice handled by the CLA per clock.
    localparam int SLICE_W = 16;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Slice counter width: clog2(words), never narrower than one bit.
    function automatic int cnt_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/cla16_multiword_seq_if.sv
// Operand/result bus of the multi-word sequencer.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The source holds valid and its payload stable until that
// edge; the sink may raise or drop ready freely. The operand port (in_*) is
// driven by the requester, the result port (out_*, result and flags) by the
// sequencer.
interface cla16_multiword_seq_if #(
    parameter int WORDS = 4
);
    localparam int W = WORDS * 16;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         busy;

    // Requester/consumer side.
    modport master (
        output in_valid, op_a, op_b, sub, out_ready,
        input  in_ready, out_valid, result, cout, ovf, zero, busy
    );

    // Sequencer side.
    modport slave (
        input  in_valid, op_a, op_b, sub, out_ready,
        output in_ready, out_valid, result, cout, ovf, zero, busy
    );

endinterface

// File: rtl/cla16_multiword_seq_cla.sv
// 16-bit two-level carry-lookahead adder: four 4-bit lookahead groups whose
// group generate/propagate feed a second lookahead level for group carries.
module CLAAdder16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o,
    output logic        p_o,
    output logic        g_o
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    // Carries into bits 0..3 of a group from its bit generate/propagate.
    function automatic logic [3:0] lookahead4(input logic [3:0] gi,
                                              input logic [3:0] pi,
                                              input logic       ci);
        logic [3:0] cc;
        cc[0] = ci;
        cc[1] = gi[0] | (pi[0] & ci);
        cc[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
        cc[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
              | (pi[2] & pi[1] & pi[0] & ci);
        return cc;
    endfunction

    // Bit P/G, group P/G, group carries, then per-bit carries and sum.
    always_comb begin
        g = a_i & b_i;
        p = a_i ^ b_i;
        for (int j = 0; j < 4; j++) begin
            gp[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
        gc[0] = cin_i;
        gc[1] = gg[0] | (gp[0] & cin_i);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin_i);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin_i);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & cin_i);
        c = '0;
        for (int j = 0; j < 4; j++) begin
            c[4*j +: 4] = lookahead4(g[4*j +: 4], p[4*j +: 4], gc[j]);
        end
        sum_o  = p ^ c;
        cout_o = gc[4];
        p_o    = &gp;
        g_o    = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]);
    end

endmodule

// File: rtl/cla16_multiword_seq.sv
// Multi-precision add/subtract sequencer. Operands are latched once, then
// streamed least-significant slice first through a single CLAAdder16, one
// slice per clock, with the inter-slice carry held in a register. Subtract
// is A + ~B + 1: B is inverted at accept time and the carry seeded with 1.
module cla16_multiword_seq
    import cla16_multiword_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    cla16_multiword_seq_if.slave        bus,
    output state_e                      dbg_state_o
);

    localparam int W  = WORDS * SLICE_W;
    localparam int CW = cnt_width(WORDS);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            carry_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    result_q;
    logic            cout_q;
    logic            ovf_q;
    logic            zero_q;

    logic [SLICE_W-1:0] cla_a;
    logic [SLICE_W-1:0] cla_b;
    logic [SLICE_W-1:0] cla_sum;
    logic               cla_cout;
    logic [W-1:0]       result_d;
    logic               ovf_d;

    // Present the current slice to the adder and build the next result image.
    always_comb begin
        cla_a    = a_q[cnt_q*SLICE_W +: SLICE_W];
        cla_b    = b_q[cnt_q*SLICE_W +: SLICE_W];
        result_d = result_q;
        result_d[cnt_q*SLICE_W +: SLICE_W] = cla_sum;
        // Only meaningful on the top slice, where cla_sum[15] is the result MSB.
        ovf_d    = (a_q[W-1] == b_q[W-1]) && (cla_sum[SLICE_W-1] != a_q[W-1]);
    end

    CLAAdder16 u_cla (
        .a_i    (cla_a),
        .b_i    (cla_b),
        .cin_i  (carry_q),
        .sum_o  (cla_sum),
        .cout_o (cla_cout),
        .p_o    (),
        .g_o    ()
    );

    // Sequencer FSM with counter, operand, carry, result and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.op_a;
                        b_q      <= bus.sub ? ~bus.op_b : bus.op_b;
                        carry_q  <= bus.sub;
                        cnt_q    <= '0;
                        result_q <= '0;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    result_q <= result_d;
                    carry_q  <= cla_cout;
                    if (cnt_q == LAST) begin
                        cout_q  <= cla_cout;
                        ovf_q   <= ovf_d;
                        zero_q  <= (result_d == '0);
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Handshake outputs depend on registered state only.
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_cla16_multiword_seq.sv
// Bench for cla16_multiword_seq (WORDS=4): directed vectors, scoreboard queue
// filled at accept time, monitor popping on every retired result.
module tb_cla16_multiword_seq;
    import cla16_multiword_seq_pkg::*;

    localparam int WORDS = 4;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_e dbg_state;
    int     cyc = 0;
    int     accept_idx = 0;
    int     total = 0;
    int     bad = 0;
    logic   ov_prev = 1'b0;
    logic [66:0] exp_q[$];

    cla16_multiword_seq_if #(.WORDS(WORDS)) bus();

    cla16_multiword_seq #(.WORDS(WORDS)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // Clock and edge counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one request and wait (bounded) for the accept edge.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic s,
                        input logic [66:0] exp);
        bit ok = 0;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.sub      = s;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            if (bus.in_ready) begin
                ok = 1;
                accept_idx = cyc + 1;
                exp_q.push_back(exp);
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end else begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) until every expected result has been retired.
    task automatic wait_idle();
        bit ok = 0;
        for (int t = 0; t < 200; t++) begin
            if (exp_q.size() == 0 && bus.in_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL idle_timeout: got pending=%0d expected 0", exp_q.size());
        end
    endtask

    // Monitor: latency on out_valid rise, scoreboard compare on retire.
    always @(negedge clk) begin
        if (rst) begin
            ov_prev = 1'b0;
        end else begin
            if (bus.out_valid && !ov_prev)
                chk("latency", 64'(cyc - accept_idx), 64'(WORDS));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_result: got %h expected none", bus.result);
                end else begin
                    logic [66:0] e;
                    e = exp_q.pop_front();
                    chk("result", bus.result, e[66:3]);
                    chk("cout", 64'(bus.cout), 64'(e[2]));
                    chk("ovf", 64'(bus.ovf), 64'(e[1]));
                    chk("zero", 64'(bus.zero), 64'(e[0]));
                end
            end
            ov_prev = bus.out_valid;
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_result", bus.result, 64'd0);
        chk("rst_flags", 64'({bus.cout, bus.ovf, bus.zero}), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));

        // Directed vectors: {result, cout, ovf, zero}.
        send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, {64'h0000_0000_0001_0000, 3'b000});
        wait_idle();
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, {64'h0, 3'b101});
        wait_idle();
        send(64'h5, 64'h7, 1'b1, {64'hFFFF_FFFF_FFFF_FFFE, 3'b000});
        wait_idle();
        send(64'h7, 64'h5, 1'b1, {64'h2, 3'b100});
        wait_idle();
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, {64'h8000_0000_0000_0000, 3'b010});
        wait_idle();
        send(64'h8000_0000_0000_0000, 64'h1, 1'b1, {64'h7FFF_FFFF_FFFF_FFFF, 3'b110});
        wait_idle();
        send(64'h0, 64'h0, 1'b1, {64'h0, 3'b101});
        wait_idle();
        send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0,
             {64'h2345_6789_ABCD_F001, 3'b000});
        wait_idle();

        // Backpressure: hold DONE while a new request is pending.
        send(64'h7, 64'h5, 1'b1, {64'h2, 3'b100});
        bus.out_ready = 1'b0;
        bus.op_a      = 64'h0000_0000_0000_FFFF;
        bus.op_b      = 64'h1;
        bus.sub       = 1'b0;
        bus.in_valid  = 1'b1;
        for (int t = 0; t < 20 && !bus.out_valid; t++) begin
            @(posedge clk); #1;
        end
        for (int k = 0; k < 3; k++) begin
            chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_result", bus.result, 64'h2);
            chk("hold_flags", 64'({bus.cout, bus.ovf, bus.zero}), 64'b100);
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
            chk("hold_state", 64'(dbg_state), 64'(ST_DONE));
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("retire_in_ready", 64'(bus.in_ready), 64'd1);
        chk("retire_busy", 64'(bus.busy), 64'd0);
        accept_idx = cyc + 1;
        exp_q.push_back({64'h0000_0000_0001_0000, 3'b000});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("pending_accepted", 64'(bus.busy), 64'd1);
        wait_idle();

        // Reset in the middle of RUN with counter at 2.
        send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0,
             {64'h2345_6789_ABCD_F001, 3'b000});
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_state", 64'(dbg_state), 64'(ST_RUN));
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mrst_busy", 64'(bus.busy), 64'd0);
        chk("mrst_result", bus.result, 64'd0);
        chk("mrst_state", 64'(dbg_state), 64'(ST_IDLE));
        send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0,
             {64'h2345_6789_ABCD_F001, 3'b000});
        wait_idle();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cla16_multiword_seq.md
Name: cla16_multiword_seq

Overview:
- Multi-precision add/subtract sequencer. Streams WORDS x 16-bit operand slices, least-significant first, through a single 16-bit carry-lookahead adder, one slice per clock.
- Carry is rippled between slices through a register.
- Sits between a requester (valid/ready operand port) and a consumer (valid/ready result port). Wide arithmetic reuses one CLA16 instead of instantiating WORDS of them.

Parameters:
- WORDS, 4, number of 16-bit slices per operation (legal range 1..16). Operand width is WORDS*16.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept a request (high only in IDLE).
- op_a  input  WORDS*16  operand A.
- op_b  input  WORDS*16  operand B.
- sub  input  1  0: A+B, 1: A-B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WORDS*16  sum/difference.
- cout  output  1  final carry out. For subtract: 1 = no borrow (A >= B unsigned).
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  result == 0.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: synchronous, active-high. Any cycle with rst=1 forces the following:
  - state = IDLE;
  - in_ready=1 after reset;
  - out_valid=0, busy=0;
  - result=0, cout=0, ovf=0, zero=0;
  - slice counter=0, carry register=0.
  - rst overrides all handshakes, including mid-RUN; the partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at edge E0:
    - latch op_a into a_reg;
    - latch op_b, or ~op_b when sub=1, into b_reg;
    - carry <= sub; counter <= 0; result <= 0;
    - go to RUN.
  - Inputs are sampled only at the accept edge; later changes are ignored.
- RUN:
  - Slice k = counter is fed to the CLA16: A = a_reg[16k+15:16k], B = b_reg slice, cin = carry.
  - At each edge:
    - result[16k+15:16k] <= sum;
    - carry <= CLA cout;
    - counter <= counter+1.
  - When counter == WORDS-1 at the edge, go to DONE instead:
    - cout <= CLA cout;
    - ovf <= (a_msb == b_msb) && (sum_msb != a_msb), using the top slice's MSBs from a_reg/b_reg (b already inverted);
    - zero <= (full registered result including this slice) == 0.
- Latency: out_valid rises exactly WORDS cycles after E0. With WORDS=1, out_valid is high one cycle after accept.
- DONE:
  - out_valid=1; result, cout, ovf and zero are held stable.
  - On out_ready=1 at an edge, go to IDLE and drop out_valid. result and flags hold their last values; they are don't-care once out_valid=0.
  - in_ready=0 in RUN and DONE. A request offered while busy is neither accepted nor lost: the requester keeps in_valid high.
  - No same-cycle result-retire plus new-accept. The earliest next accept is the cycle after retire, so throughput is one op per WORDS+2 cycles with an always-ready consumer.
- Outputs in_ready, out_valid and busy are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- Carry arithmetic is modulo 2^(WORDS*16). cout is the carry out of bit WORDS*16-1.

Decomposition:
- Shared package: state encoding constants (IDLE, RUN, DONE), slice width constant 16, counter width = clog2(WORDS) with a minimum of 1.
- Sub-module: instantiate the codebase's existing 16-bit CLA adder (CLAAdder16) once as the slice datapath.
  - Only its sum and cout are used.
  - Block P/G outputs are left unconnected.
- The FSM, counter, operand registers and flag logic live in this module. Expected size is about 150-250 lines.

Test Plan (WORDS=4):
- Add across a slice boundary: A=0x0000_0000_0000_FFFF, B=0x1, sub=0 -> result=0x0000_0000_0001_0000, cout=0, ovf=0, zero=0; out_valid high exactly 4 cycles after the accept edge.
- Full-width wrap: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1 -> result=0x0, cout=1, zero=1, ovf=0.
- Subtract with borrow: A=0x5, B=0x7, sub=1 -> result=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Then A=0x7, B=0x5 -> result=0x2, cout=1.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=0x1 -> result=0x8000_0000_0000_0000, ovf=1, cout=0. A=0x8000_0000_0000_0000 minus B=0x1 -> result=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands.
  - While held: result and flags stable, in_ready=0, nothing accepted.
  - On out_ready=1: IDLE next cycle, and the pending request is accepted one cycle later with the correct result.
- Reset mid-operation: assert rst for one cycle when counter=2 in RUN -> next cycle IDLE, in_ready=1, out_valid=0, busy=0, result=0. A following request completes normally.
